// File: rtl/alu_op_sequencer.sv
// Self-test sequencer for the 12-bit one-hot ALU control interface: latches an operand
// pair, steps every opcode, streams each settled result and folds it into a signature.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned NUM_OPS       = 12
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] src1_in,
    input  logic [31:0] src2_in,
    output logic [11:0] alu_control,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic [3:0]  op_index,
    output logic [31:0] signature
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_OP     = 4'(NUM_OPS - 1);

    state_t      state_r, state_nxt_s;
    logic [7:0]  settle_cnt_r, settle_cnt_nxt_s;
    logic [3:0]  op_cnt_r, op_cnt_nxt_s;
    logic [11:0] ctrl_r, ctrl_nxt_s;
    logic [31:0] src1_r, src1_nxt_s, src2_r, src2_nxt_s;
    logic [31:0] rdata_r, rdata_nxt_s, sig_r, sig_nxt_s;
    logic [3:0]  op_index_r, op_index_nxt_s;
    logic        busy_r, done_r, rvalid_r;
    logic        sample_s;

    // An abort at the sampling edge suppresses the sample entirely.
    assign sample_s = (state_r == ST_RUN) && !abort && (settle_cnt_r == SETTLE_LAST);

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= 8'd0;
            op_cnt_r     <= 4'd0;
            ctrl_r       <= 12'd0;
            src1_r       <= 32'd0;
            src2_r       <= 32'd0;
            rdata_r      <= 32'd0;
            sig_r        <= 32'd0;
            op_index_r   <= 4'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rvalid_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            settle_cnt_r <= settle_cnt_nxt_s;
            op_cnt_r     <= op_cnt_nxt_s;
            ctrl_r       <= ctrl_nxt_s;
            src1_r       <= src1_nxt_s;
            src2_r       <= src2_nxt_s;
            rdata_r      <= rdata_nxt_s;
            sig_r        <= sig_nxt_s;
            op_index_r   <= op_index_nxt_s;
            busy_r       <= (state_nxt_s == ST_RUN);
            done_r       <= (state_nxt_s == ST_DONE);
            rvalid_r     <= sample_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (abort)                                 state_nxt_s = ST_IDLE;
                else if (sample_s && (op_cnt_r == LAST_OP)) state_nxt_s = ST_DONE;
                else                                       state_nxt_s = ST_RUN;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and counters.
    always_comb begin
        settle_cnt_nxt_s = settle_cnt_r;
        op_cnt_nxt_s     = op_cnt_r;
        ctrl_nxt_s       = ctrl_r;
        src1_nxt_s       = src1_r;
        src2_nxt_s       = src2_r;
        rdata_nxt_s      = rdata_r;
        sig_nxt_s        = sig_r;
        op_index_nxt_s   = op_index_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    src1_nxt_s       = src1_in;
                    src2_nxt_s       = src2_in;
                    sig_nxt_s        = 32'd0;
                    op_cnt_nxt_s     = 4'd0;
                    settle_cnt_nxt_s = 8'd0;
                    ctrl_nxt_s       = 12'h001;
                end else begin
                    ctrl_nxt_s = 12'd0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    ctrl_nxt_s = 12'd0;
                end else if (sample_s) begin
                    rdata_nxt_s      = alu_result;
                    op_index_nxt_s   = op_cnt_r;
                    sig_nxt_s        = {sig_r[30:0], sig_r[31]} ^ alu_result;
                    settle_cnt_nxt_s = 8'd0;
                    op_cnt_nxt_s     = op_cnt_r + 4'd1;
                    if (op_cnt_r == LAST_OP) ctrl_nxt_s = 12'd0;
                    else                     ctrl_nxt_s = ctrl_r << 1;
                end else begin
                    settle_cnt_nxt_s = settle_cnt_r + 8'd1;
                end
            end
            ST_DONE: ctrl_nxt_s = 12'd0;
            default: ctrl_nxt_s = 12'd0;
        endcase
    end

    assign alu_control  = ctrl_r;
    assign alu_src1     = src1_r;
    assign alu_src2     = src2_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign result_valid = rvalid_r;
    assign result_data  = rdata_r;
    assign op_index     = op_index_r;
    assign signature    = sig_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 4 and settle 1) against a cycle-timing
// reference derived from the sweep schedule, with a stub ALU on each.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  start_v;
    logic        abort;
    logic [31:0] src1_in, src2_in;
    logic [11:0] ctrl_v [2];
    logic [31:0] s1_v [2], s2_v [2], res_v [2], rd_v [2], sig_v [2];
    logic        busy_v [2], done_v [2], rv_v [2];
    logic [3:0]  opi_v [2];
    int          mode;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    // Stub ALU: echo, constant, or a small real ALU keyed by the one-hot opcode.
    function automatic logic [31:0] stub_alu(input logic [11:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input int md);
        if (md == 0) return {20'd0, c};
        if (md == 1) return 32'h8000_0000;
        case (c)
            12'h001: return a + b;
            12'h002: return a - b;
            12'h004: return a & b;
            12'h008: return a | b;
            12'h010: return a ^ b;
            12'h020: return ~(a | b);
            12'h040: return a << b[4:0];
            12'h080: return a >> b[4:0];
            12'h100: return 32'($signed(a) >>> b[4:0]);
            12'h200: return {31'd0, ($signed(a) < $signed(b))};
            12'h400: return {31'd0, (a < b)};
            12'h800: return {b[15:0], 16'd0};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return (x << 1) | (x >> 31);
    endfunction

    function automatic int sval(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Expected signature after the first n ops of a sweep on operands a, b.
    function automatic logic [31:0] sig_after(input int n, input logic [31:0] a,
                                              input logic [31:0] b, input int md);
        logic [31:0] s;
        logic [11:0] oh;
        s = 32'd0;
        for (int i = 0; i < n; i++) begin
            oh = 12'd1 << i;
            s  = rotl1(s) ^ stub_alu(oh, a, b, md);
        end
        return s;
    endfunction

    assign res_v[0] = stub_alu(ctrl_v[0], s1_v[0], s2_v[0], mode);
    assign res_v[1] = stub_alu(ctrl_v[1], s1_v[1], s2_v[1], mode);

    alu_op_sequencer #(.SETTLE_CYCLES(4), .NUM_OPS(12)) dut4 (
        .clk(clk), .resetn(resetn), .start(start_v[0]), .abort(abort),
        .src1_in(src1_in), .src2_in(src2_in), .alu_control(ctrl_v[0]),
        .alu_src1(s1_v[0]), .alu_src2(s2_v[0]), .alu_result(res_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .result_valid(rv_v[0]),
        .result_data(rd_v[0]), .op_index(opi_v[0]), .signature(sig_v[0])
    );

    alu_op_sequencer #(.SETTLE_CYCLES(1), .NUM_OPS(12)) dut1 (
        .clk(clk), .resetn(resetn), .start(start_v[1]), .abort(abort),
        .src1_in(src1_in), .src2_in(src2_in), .alu_control(ctrl_v[1]),
        .alu_src1(s1_v[1]), .alu_src2(s2_v[1]), .alu_result(res_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .result_valid(rv_v[1]),
        .result_data(rd_v[1]), .op_index(opi_v[1]), .signature(sig_v[1])
    );

    task automatic test_reset();
        resetn = 1'b0; start_v = 2'b00; abort = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({ctrl_v[d], s1_v[d], s2_v[d], busy_v[d], done_v[d], rv_v[d], rd_v[d],
                 opi_v[d], sig_v[d]} !== 147'd0) begin
                miscompares++;
                $display("FAIL reset dut%0d: ctrl=%h src1=%h src2=%h busy=%b done=%b rv=%b rd=%h op=%0d sig=%h, all required 0",
                         d, ctrl_v[d], s1_v[d], s2_v[d], busy_v[d], done_v[d], rv_v[d],
                         rd_v[d], opi_v[d], sig_v[d]);
            end
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Full sweep on both instances with start re-pulsed in RUN and in DONE.
    task automatic test_sweep(input int md, input logic with_abort);
        logic [31:0] a, b, exp_sig, exp_rd;
        logic [11:0] exp_ctrl;
        logic        exp_busy, exp_done, exp_rv;
        int          s, total, nsamp;
        a = (md == 1) ? 32'h0000_1111 : $urandom;
        b = $urandom;
        mode = md;
        @(negedge clk);
        start_v = 2'b11; abort = with_abort; src1_in = a; src2_in = b;
        @(posedge clk); @(negedge clk);
        start_v = 2'b00; abort = 1'b0;
        for (int m = 0; m <= 51; m++) begin
            for (int d = 0; d < 2; d++) begin
                s        = sval(d);
                total    = 12 * s;
                exp_busy = (m < total);
                exp_done = (m == total);
                exp_rv   = (m >= s) && (m <= total) && (m % s == 0);
                exp_ctrl = (m < total) ? (12'd1 << (m / s)) : 12'd0;
                nsamp    = (m >= total) ? 12 : (m / s);
                exp_sig  = sig_after(nsamp, a, b, md);
                vectors++;
                if (ctrl_v[d] !== exp_ctrl || busy_v[d] !== exp_busy || done_v[d] !== exp_done ||
                    rv_v[d] !== exp_rv) begin
                    miscompares++;
                    $display("FAIL sweep_ctl md%0d dut%0d m=%0d: ctrl=%h busy=%b done=%b rv=%b, required ctrl=%h busy=%b done=%b rv=%b",
                             md, d, m, ctrl_v[d], busy_v[d], done_v[d], rv_v[d],
                             exp_ctrl, exp_busy, exp_done, exp_rv);
                end
                vectors++;
                if (sig_v[d] !== exp_sig || s1_v[d] !== a || s2_v[d] !== b) begin
                    miscompares++;
                    $display("FAIL sweep_data md%0d dut%0d m=%0d: sig=%h src1=%h src2=%h, required sig=%h src1=%h src2=%h",
                             md, d, m, sig_v[d], s1_v[d], s2_v[d], exp_sig, a, b);
                end
                if (exp_rv || m > total) begin
                    nsamp  = (m > total) ? 11 : (m / s - 1);
                    exp_rd = stub_alu(12'd1 << nsamp, a, b, md);
                    vectors++;
                    if (rd_v[d] !== exp_rd || opi_v[d] !== 4'(nsamp)) begin
                        miscompares++;
                        $display("FAIL sweep_result md%0d dut%0d m=%0d: rd=%h op=%0d, required rd=%h op=%0d",
                                 md, d, m, rd_v[d], opi_v[d], exp_rd, nsamp);
                    end
                end
            end
            src1_in = $urandom; src2_in = $urandom;
            for (int d = 0; d < 2; d++)
                start_v[d] = (m == 5) || (m == 12 * sval(d));
            @(posedge clk); @(negedge clk);
        end
        start_v = 2'b00;
    endtask

    // Abort on the settle-4 instance exactly at op 3's sampling edge.
    task automatic test_abort();
        logic [31:0] a, b, exp_sig, exp_rd;
        logic [11:0] exp_ctrl;
        logic        exp_busy, exp_rv;
        a = $urandom; b = $urandom;
        mode = 2;
        @(negedge clk);
        start_v = 2'b01; src1_in = a; src2_in = b;
        @(posedge clk); @(negedge clk);
        start_v = 2'b00;
        for (int m = 0; m <= 24; m++) begin
            exp_busy = (m < 16);
            exp_ctrl = (m < 16) ? (12'd1 << (m / 4)) : 12'd0;
            exp_rv   = (m == 4) || (m == 8) || (m == 12);
            exp_sig  = sig_after((m < 16) ? (m / 4) : 3, a, b, 2);
            vectors++;
            if (ctrl_v[0] !== exp_ctrl || busy_v[0] !== exp_busy || rv_v[0] !== exp_rv ||
                done_v[0] !== 1'b0 || sig_v[0] !== exp_sig) begin
                miscompares++;
                $display("FAIL abort m=%0d: ctrl=%h busy=%b rv=%b done=%b sig=%h, required ctrl=%h busy=%b rv=%b done=0 sig=%h",
                         m, ctrl_v[0], busy_v[0], rv_v[0], done_v[0], sig_v[0],
                         exp_ctrl, exp_busy, exp_rv, exp_sig);
            end
            if (m >= 16) begin
                exp_rd = stub_alu(12'h004, a, b, 2);
                vectors++;
                if (rd_v[0] !== exp_rd || opi_v[0] !== 4'd2 || busy_v[1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL abort_hold m=%0d: rd=%h op=%0d idle_busy=%b, required rd=%h op=2 idle_busy=0",
                             m, rd_v[0], opi_v[0], busy_v[1], exp_rd);
                end
            end
            abort = (m == 15) || (m == 20);
            @(posedge clk); @(negedge clk);
        end
        abort = 1'b0;
    endtask

    // Reset pulse while the settle-4 instance is on op 5.
    task automatic test_reset_midrun();
        mode = 0;
        @(negedge clk);
        start_v = 2'b11; src1_in = $urandom; src2_in = $urandom;
        @(posedge clk); @(negedge clk);
        start_v = 2'b00;
        for (int m = 0; m <= 30; m++) begin
            if (m == 21) begin
                vectors++;
                if (ctrl_v[0] !== 12'h020 || busy_v[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rst_pre: ctrl=%h busy=%b, required ctrl=020 busy=1",
                             ctrl_v[0], busy_v[0]);
                end
            end
            if (m >= 22) begin
                for (int d = 0; d < 2; d++) begin
                    vectors++;
                    if ({ctrl_v[d], s1_v[d], s2_v[d], busy_v[d], done_v[d], rv_v[d], rd_v[d],
                         opi_v[d], sig_v[d]} !== 147'd0) begin
                        miscompares++;
                        $display("FAIL rst_mid dut%0d m=%0d: ctrl=%h src1=%h busy=%b done=%b rv=%b rd=%h sig=%h, all required 0",
                                 d, m, ctrl_v[d], s1_v[d], busy_v[d], done_v[d], rv_v[d],
                                 rd_v[d], sig_v[d]);
                    end
                end
            end
            resetn = (m == 21) ? 1'b0 : 1'b1;
            @(posedge clk); @(negedge clk);
        end
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; start_v = 2'b00; abort = 1'b0;
        src1_in = 32'd0; src2_in = 32'd0; mode = 0;
        test_reset();
        test_sweep(0, 1'b0);
        test_sweep(1, 1'b0);
        test_sweep(2, 1'b1);
        test_abort();
        test_reset_midrun();
        test_sweep(2, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Self-test sequencer that drives the 12-bit one-hot ALU control interface. It is the initiator side of that interface: it drives alu_control, alu_src1 and alu_src2, and consumes alu_result.
- On start, it latches one operand pair and steps through all 12 one-hot opcodes, holding each for SETTLE_CYCLES cycles.
- It samples each result, streams it out, and folds it into a 32-bit rotate-XOR signature.
- It sits beside the ALU in lab bring-up and board self-test, and replaces hand-timed stimulus.

Parameters:
- SETTLE_CYCLES, 4, cycles each opcode is held before alu_result is sampled. Legal range is 1..255.
- NUM_OPS, 12, number of one-hot opcodes stepped. Equals the alu_control width and is fixed at 12.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  request a sweep. Sampled only in IDLE.
- abort  input  1  cancel a sweep in progress. Sampled only in RUN.
- src1_in  input  32  operand A, latched on start acceptance.
- src2_in  input  32  operand B, latched on start acceptance.
- alu_control  output  12  one-hot opcode to the ALU; 0 when not running.
- alu_src1  output  32  latched operand A.
- alu_src2  output  32  latched operand B.
- alu_result  input  32  combinational ALU result.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a sweep completes.
- result_valid  output  1  one-cycle pulse per sampled result.
- result_data  output  32  sampled alu_result.
- op_index  output  4  index (0..11) of the opcode result_data belongs to.
- signature  output  32  running rotate-XOR signature.

Behaviour:
- Reset: when resetn is low at a rising edge, the following clear at that edge:
  - state to IDLE;
  - all outputs (alu_control, alu_src1, alu_src2, busy, done, result_valid, result_data, op_index, signature) to 0;
  - internal counters to 0.
- Reset overrides every other input, including mid-sweep, with no done pulse.
- States:
  - IDLE: alu_control=0, busy=0.
  - RUN: busy=1.
  - DONE: lasts one cycle; done=1, alu_control=0.
- IDLE -> RUN, when start=1 at edge E:
  - latch alu_src1<=src1_in, alu_src2<=src2_in;
  - signature<=0, op counter<=0, settle counter<=0;
  - alu_control<=12'h001.
- RUN, each edge: the settle counter increments.
  - When the counter is SETTLE_CYCLES-1 at an edge, sample at that edge:
    - result_data<=alu_result;
    - op_index<=current op;
    - result_valid<=1 for the next cycle only;
    - signature<={signature[30:0],signature[31]}^alu_result.
  - Then, at the same edge, advance: counter<=0, alu_control<=alu_control<<1, op+1.
- Timing: op i is driven for the cycles following edges E+S*i .. E+S*i+S-1 and sampled at edge E+S*(i+1), where S=SETTLE_CYCLES. With S=1, every edge in RUN samples and advances.
- Last op (i=11) sampled -> DONE:
  - alu_control<=0, busy<=0, done<=1;
  - the result_valid pulse for op 11 coincides with done.
- DONE -> IDLE on the next edge; done falls.
- abort=1 in RUN -> IDLE on the next edge:
  - alu_control<=0, busy<=0, no done;
  - no sample is taken at that edge even if the counter is at its limit;
  - signature, result_data and op_index keep their last values.
  - abort in IDLE or DONE is ignored.
- start while in RUN or DONE is ignored; there is no queuing.
- start and abort high together in IDLE: start wins.
- alu_src1, alu_src2, signature and result_data hold after a sweep until the next start acceptance or reset.
- alu_control is always 0 or exactly one-hot; it never has two bits set.

Test Plan:
- Reset during RUN (op 5): resetn=0 for one edge -> every output reads 0 after that edge; no done pulse; a later start runs a full sweep.
- S=4, stub ALU echoing {20'b0, alu_control}, start at edge E:
  - busy high for 48 cycles; done high for exactly the cycle after edge E+48;
  - 12 result_valid pulses at edges E+4, E+8, ..., E+48;
  - result_data = 1<<op_index for each pulse; final signature = 32'h00000000.
- Stub ALU constant 32'h80000000 -> final signature = 32'h800007FF; alu_src1/alu_src2 equal the src inputs latched at start (e.g. 32'h00001111), unchanged by src changes mid-run.
- S=1 -> alu_control steps 001,002,...,800 on consecutive cycles, result_valid stays high 12 consecutive cycles, done at edge E+12.
- abort=1 during op 3, counter at SETTLE_CYCLES-1 -> IDLE next edge, alu_control=0, no result_valid for op 3, no done, signature holds its op-2 value.
- start pulsed in RUN and in the DONE cycle -> ignored, busy not re-asserted; start=1 with abort=1 in IDLE -> sweep begins.
